wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
Parametrised N-master to 1-slave Wishbone classic arbiter for the processor_ci core space. It lets several core-side bus masters share one memory/controller bus, for example instruction fetch, data port and a debug/DMA master. Grants are round-robin and held for the full cyc_o cycle. A programmable per-transaction ack timeout returns an error to the master instead of hanging the core. It sits between the core's bus ports and the Controller core_* bus, replacing the separate second-memory path when a single shared memory is used.

Parameters:
NUM_MASTERS, 2, number of master ports (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)
TIMEOUT_CYCLES, 1024, cycles without ack before error; 0 disables timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m_cyc_i  in  NUM_MASTERS  per-master cyc
m_stb_i  in  NUM_MASTERS  per-master stb
m_we_i  in  NUM_MASTERS  per-master write enable
m_wstrb_i  in  NUM_MASTERS*DATA_WIDTH/8  byte strobes, master k at slice k
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  addresses, packed
m_data_i  in  NUM_MASTERS*DATA_WIDTH  write data, packed
m_data_o  out  DATA_WIDTH  read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  ack, granted master only
m_err_o  out  NUM_MASTERS  timeout error pulse, granted master only
s_cyc_o  out  1  slave cyc
s_stb_o  out  1  slave stb
s_we_o  out  1  slave we
s_wstrb_o  out  DATA_WIDTH/8  slave strobes
s_addr_o  out  ADDR_WIDTH  slave address
s_data_o  out  DATA_WIDTH  slave write data
s_data_i  in  DATA_WIDTH  slave read data
s_ack_i  in  1  slave ack
grant_o  out  NUM_MASTERS  one-hot current grant (0 in IDLE)

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - grant_o, s_* outputs, m_ack_o, m_err_o and the timeout counter are all 0.
  - last_grant = NUM_MASTERS-1, so master 0 wins the first arbitration.
  - Reset asserted mid-transaction aborts it with no ack and no err.
- FSM states: IDLE, BUSY.
- IDLE:
  - A master requests when m_cyc_i[k] & m_stb_i[k].
  - Winner is the first requester searching from (last_grant+1) mod NUM_MASTERS upward with wrap.
  - The winner is registered into grant and the FSM moves to BUSY. s_cyc_o rises on the next cycle, giving 1 cycle of arbitration latency.
  - No requesters: stay in IDLE.
- BUSY, with g = granted index:
  - s_cyc_o = m_cyc_i[g]. s_stb_o, s_we_o, s_wstrb_o, s_addr_o and s_data_o are the combinational mux of master g.
  - m_ack_o[g] = s_ack_i in the same cycle (0-cycle pass-through). All other m_ack_o bits are 0.
  - m_data_o = s_data_i at all times.
  - The grant is held while m_cyc_i[g]=1, so multi-beat transfers with stb toggling stay with one master.
  - When m_cyc_i[g]=0: go to IDLE, last_grant=g, grant cleared. This gives at least one IDLE cycle between owners, so back-to-back different masters see a 1-cycle bubble.
- Outside BUSY: s_* outputs are driven 0, and s_ack_i is ignored (no m_ack_o).
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments in BUSY on each cycle with s_stb_o=1 and s_ack_i=0.
  - It clears on s_ack_i, on stb low, and on leaving BUSY.
  - When the count reaches TIMEOUT_CYCLES, in the following cycle:
    - m_err_o[g]=1 for exactly 1 cycle;
    - s_cyc_o and s_stb_o are forced to 0;
    - the FSM goes to IDLE with last_grant=g.
  - A late s_ack_i arriving after the timeout is ignored.
  - If s_ack_i and the timeout threshold coincide, the ack wins: it is passed through and no error is raised.
- Counter width: clog2(TIMEOUT_CYCLES+1), saturating. Grant index width: clog2(NUM_MASTERS), min 1.
- A master whose m_cyc_i drops while not granted simply withdraws its request.
- A master holding cyc without stb keeps the grant indefinitely (by design). No timeout applies without stb.

Test Plan:
- Single master: m0 reads addr 0x0000_0010, slave acks with 0xCAFEBABE 2 cycles after s_stb_o → s_cyc_o rises 1 cycle after request, m_ack_o=2'b01 in the same cycle as s_ack_i, m_data_o=0xCAFEBABE, grant_o returns to 0 after m0 drops cyc.
- Simultaneous requests from reset: m0 and m1 both request continuously for 4 transactions → grants alternate m0, m1, m0, m1, with one IDLE bubble between each.
- NUM_MASTERS=4 with only m1 and m3 requesting, last_grant=3 → m1 is granted, then m3, then m1; m0 and m2 are never granted.
- Burst hold: m1 keeps cyc high for 3 beats (stb 1,0,1,1), each acked; m0 requests meanwhile → m0 is granted only after m1 drops cyc. s_addr_o follows m1 for all beats, and m0 never sees an ack.
- Timeout with TIMEOUT_CYCLES=8: slave never acks m0 → m_err_o[0]=1 for 1 cycle, 9 cycles after s_stb_o rose; s_cyc_o=0 in that cycle; a late s_ack_i produces no m_ack_o; m1 is granted next.
- Reset mid-BUSY: rst_n pulled low while m0 is granted and waiting for ack → all outputs 0 immediately; after release, master 0 is granted first.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter. Round-robin grant is held for
// the whole cyc; a stalled slave is cut off after TIMEOUT_CYCLES with an err pulse.

module wb_rr_port (
  input  logic cyc,
  input  logic stb,
  input  logic sel,
  input  logic ack_en,
  input  logic err_en,
  output logic req,
  output logic ack,
  output logic err
);
  assign req = cyc & stb;
  assign ack = sel & ack_en;
  assign err = sel & err_en;
endmodule

module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_MASTERS-1:0]             m_cyc_i,
  input  logic [NUM_MASTERS-1:0]             m_stb_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_data_i,
  output logic [DATA_WIDTH-1:0]              m_data_o,
  output logic [NUM_MASTERS-1:0]             m_ack_o,
  output logic [NUM_MASTERS-1:0]             m_err_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  output logic [DATA_WIDTH/8-1:0]            s_wstrb_o,
  output logic [ADDR_WIDTH-1:0]              s_addr_o,
  output logic [DATA_WIDTH-1:0]              s_data_o,
  input  logic [DATA_WIDTH-1:0]              s_data_i,
  input  logic                               s_ack_i,
  output logic [NUM_MASTERS-1:0]             grant_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                                state_q, state_d;
  logic [GW-1:0]                         grant_q, grant_d, last_q, last_d, win_idx, idx;
  logic                                  win_vld;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic                                  tmo_q, tmo_d;
  logic                                  busy, ack_en;
  logic [NUM_MASTERS-1:0]                req, sel;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] data_v;
  logic [NUM_MASTERS-1:0][SW-1:0]         strb_v;

  assign addr_v = m_addr_i;
  assign data_v = m_data_i;
  assign strb_v = m_wstrb_i;

  assign busy   = (state_q == BUSY);
  // tmo_q marks the abort cycle: the slave is detached, so a late ack must not leak through
  assign ack_en = busy & ~tmo_q & s_ack_i;

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_port
    assign sel[k] = busy && (grant_q == GW'(k));
    wb_rr_port u_port (
      .cyc    (m_cyc_i[k]),
      .stb    (m_stb_i[k]),
      .sel    (sel[k]),
      .ack_en (ack_en),
      .err_en (tmo_q),
      .req    (req[k]),
      .ack    (m_ack_o[k]),
      .err    (m_err_o[k])
    );
  end

  assign grant_o  = sel;
  assign m_data_o = s_data_i;

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_wstrb_o = '0;
    s_addr_o  = '0;
    s_data_o  = '0;
    if (busy) begin
      s_cyc_o   = m_cyc_i[grant_q] & ~tmo_q;
      s_stb_o   = m_stb_i[grant_q] & ~tmo_q;
      s_we_o    = m_we_i[grant_q];
      s_wstrb_o = strb_v[grant_q];
      s_addr_o  = addr_v[grant_q];
      s_data_o  = data_v[grant_q];
    end
  end

  // Search starts just past the previous owner so every requester is served in turn
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = GW'((int'(last_q) + i) % NUM_MASTERS);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          grant_d = win_idx;
        end
      end
      BUSY: begin
        if (tmo_q || !m_cyc_i[grant_q]) begin
          state_d = IDLE;
          last_d  = grant_q;
          grant_d = '0;
        end else if (TIMEOUT_CYCLES > 0 && s_stb_o && !s_ack_i) begin
          // an ack in the threshold cycle takes the else path, so the ack wins
          cnt_d = (cnt_q == TMO_MAX) ? cnt_q : cnt_q + 1'b1;
          tmo_d = (cnt_q == TMO_MAX);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against an owner/round-robin/wait-count model.

module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]          cyc = '0, stb = '0, we = '0;
  logic [N-1:0][SW-1:0]  strb = '0;
  logic [N-1:0][AW-1:0]  addr = '0;
  logic [N-1:0][DW-1:0]  wdat = '0;
  logic [DW-1:0]         s_data_i = '0;
  logic                  s_ack_i = 1'b0;
  logic [DW-1:0]         m_data_o, s_data_o;
  logic [N-1:0]          m_ack_o, m_err_o, grant_o;
  logic                  s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0]         s_wstrb_o;
  logic [AW-1:0]         s_addr_o;

  int pass_cnt = 0, total_cnt = 0;

  // slave responder controls
  int          slv_lat = -1;
  int          slv_cnt = 0;
  bit          ack_nxt = 1'b0;
  bit          force_ack = 1'b0;
  logic [DW-1:0] rdata = '0;

  // reference model state
  int owner = -1, last_g = N - 1, waited = 0;
  bit err_now = 1'b0;

  int seq [8];
  int nseq = 0, iters = 0;
  logic [N-1:0] gseen = '0;

  logic bst_stb [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic bst_ack [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [AW-1:0] bst_addr [7] = '{32'h200, 32'h200, 32'h204, 32'h204, 32'h204, 32'h208, 32'h208};

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_wstrb_i(strb),
    .m_addr_i(addr), .m_data_i(wdat), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_wstrb_o(s_wstrb_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: one owner at a time, rotating search from the last owner, wait counter
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      owner = -1; last_g = N - 1; waited = 0; err_now = 1'b0;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_g + k) % N;
        if (owner < 0 && cyc[c] && stb[c]) owner = c;
      end
      waited = 0;
    end else if (err_now || !cyc[owner]) begin
      last_g = owner; owner = -1; err_now = 1'b0; waited = 0;
    end else if (stb[owner] && !s_ack_i) begin
      if (waited >= TO) err_now = 1'b1;
      else waited++;
    end else begin
      waited = 0;
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin : cmp
    logic ecyc, estb, ewe;
    logic [SW-1:0] estrb;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edat;
    logic [N-1:0]  eg, eack, eerr;
    forever begin
      @(negedge clk);
      ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; estrb = '0; eaddr = '0; edat = '0;
      eg = '0; eack = '0; eerr = '0;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        ecyc  = !err_now && cyc[owner];
        estb  = !err_now && stb[owner];
        ewe   = we[owner];
        estrb = strb[owner];
        eaddr = addr[owner];
        edat  = wdat[owner];
        if (!err_now && s_ack_i) eack = eg;
        if (err_now) eerr = eg;
      end
      chk("cycle",
          {grant_o, s_cyc_o, s_stb_o, s_we_o, s_wstrb_o, s_addr_o, s_data_o, m_ack_o, m_err_o, m_data_o},
          {eg, ecyc, estb, ewe, estrb, eaddr, edat, eack, eerr, s_data_i});
    end
  end

  // Slave: acks slv_lat cycles after stb first seen (never if slv_lat <= 0)
  initial forever begin
    @(negedge clk);
    if (s_cyc_o && s_stb_o && !s_ack_i) slv_cnt++;
    else slv_cnt = 0;
    ack_nxt = (slv_lat > 0) && (slv_cnt == slv_lat);
  end

  initial forever begin
    @(posedge clk);
    #2;
    s_ack_i  = ack_nxt | force_ack;
    s_data_i = (ack_nxt | force_ack) ? rdata : '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    cyc = '0; stb = '0; force_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Masters in mask request continuously; an acked master drops cyc for one cycle
  task automatic run_txns(input logic [N-1:0] mask, input int ntx);
    logic [N-1:0] drop;
    drop = '0; nseq = 0; iters = 0; gseen = '0;
    while (nseq < ntx && iters < 200) begin
      cyc = mask & ~drop;
      stb = mask & ~drop;
      drop = '0;
      @(negedge clk);
      iters++;
      gseen |= grant_o;
      if (m_ack_o != '0) begin
        for (int k = 0; k < N; k++) if (m_ack_o[k]) seq[nseq] = k;
        nseq++;
        drop = m_ack_o;
      end
      tick();
    end
    if (nseq < ntx) chk("txn_budget", nseq, ntx);
    cyc = '0; stb = '0;
    tick();
    tick();
  endtask

  initial begin
    logic [N-1:0] eacc;
    we = 4'b1010;
    strb[0] = 4'hF; strb[1] = 4'h3; strb[2] = 4'h1; strb[3] = 4'h8;
    wdat[0] = 32'hA000_0000; wdat[1] = 32'hB111_0001;
    wdat[2] = 32'hC222_0002; wdat[3] = 32'hD333_0003;

    // reset state
    tick();
    @(negedge clk);
    chk("rst_grant", grant_o, 0);
    chk("rst_s_cyc_stb", {s_cyc_o, s_stb_o}, 0);
    chk("rst_ack_err", {m_ack_o, m_err_o}, 0);
    tick();
    rst_n = 1'b1;

    // single master read
    slv_lat = 2; rdata = 32'hCAFE_BABE;
    addr[0] = 32'h0000_0010; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk); chk("t1_arb_latency", s_cyc_o, 0); tick();
    @(negedge clk);
    chk("t1_cyc_rise", s_cyc_o, 1);
    chk("t1_addr", s_addr_o, 32'h10);
    chk("t1_grant", grant_o, 4'b0001);
    tick();
    @(negedge clk); chk("t1_no_ack_yet", m_ack_o, 0); tick();
    @(negedge clk);
    chk("t1_ack", m_ack_o, 4'b0001);
    chk("t1_rdata", m_data_o, 32'hCAFE_BABE);
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk); tick();
    @(negedge clk); chk("t1_grant_clr", grant_o, 0);

    // two masters from reset alternate
    do_reset();
    slv_lat = 1; rdata = 32'h1234_5678;
    addr[0] = 32'h100; addr[1] = 32'h104;
    run_txns(4'b0011, 4);
    chk("t2_seq0", seq[0], 0);
    chk("t2_seq1", seq[1], 1);
    chk("t2_seq2", seq[2], 0);
    chk("t2_seq3", seq[3], 1);
    chk("t2_cycles", iters, 15);

    // sparse requesters m1, m3
    do_reset();
    addr[3] = 32'h30C;
    run_txns(4'b1010, 3);
    chk("t3_seq0", seq[0], 1);
    chk("t3_seq1", seq[1], 3);
    chk("t3_seq2", seq[2], 1);
    chk("t3_grant_seen", gseen, 4'b1010);
    chk("t3_cycles", iters, 11);

    // burst hold by m1 while m0 waits
    do_reset();
    slv_lat = 1;
    addr[1] = 32'h200; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk); tick();
    for (int i = 0; i < 7; i++) begin
      cyc[1] = 1'b1; stb[1] = bst_stb[i]; addr[1] = bst_addr[i];
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 32'h0;
      @(negedge clk);
      chk("t4_hold_grant", grant_o, 4'b0010);
      chk("t4_addr", s_addr_o, bst_addr[i]);
      chk("t4_ack", m_ack_o, bst_ack[i] ? 4'b0010 : 4'b0000);
      tick();
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk); chk("t4_release_grant", grant_o, 4'b0010); tick();
    @(negedge clk); chk("t4_bubble", grant_o, 0); tick();
    @(negedge clk); chk("t4_m0_grant", grant_o, 4'b0001); tick();
    @(negedge clk); chk("t4_m0_ack", m_ack_o, 4'b0001); tick();
    cyc = '0; stb = '0;
    tick(); tick();

    // timeout with no slave ack
    do_reset();
    slv_lat = -1;
    addr[0] = 32'h300; addr[1] = 32'h304;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk); tick();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk); chk("t5_stb_rise", s_stb_o, 1); tick();
    eacc = '0;
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      eacc |= m_err_o;
      if (i == 9) chk("t5_stb_held", s_stb_o, 1);
      tick();
    end
    chk("t5_err_early", eacc, 0);
    force_ack = 1'b1;
    @(negedge clk);
    chk("t5_err", m_err_o, 4'b0001);
    chk("t5_cyc_forced", s_cyc_o, 0);
    chk("t5_stb_forced", s_stb_o, 0);
    chk("t5_late_ack", m_ack_o, 0);
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    chk("t5_err_one_cycle", m_err_o, 0);
    chk("t5_late_ack_idle", m_ack_o, 0);
    tick();
    force_ack = 1'b0;
    @(negedge clk); chk("t5_next_grant", grant_o, 4'b0010); tick();
    cyc = '0; stb = '0;
    tick(); tick();

    // ack exactly at the timeout threshold wins
    do_reset();
    slv_lat = TO; rdata = 32'h5A5A_0001;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk); tick();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); tick();
    end
    @(negedge clk);
    chk("t5b_ack_at_limit", m_ack_o, 4'b0001);
    chk("t5b_err_at_limit", m_err_o, 0);
    tick();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk); chk("t5b_no_err", m_err_o, 0); tick();
    tick();

    // reset while busy
    do_reset();
    slv_lat = -1;
    addr[0] = 32'h400; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk); tick();
    @(negedge clk);
    chk("t6_busy", s_cyc_o, 1);
    #2 rst_n = 1'b0;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    #1;
    chk("t6_rst_grant", grant_o, 0);
    chk("t6_rst_s_bus", {s_cyc_o, s_stb_o, s_addr_o}, 0);
    chk("t6_rst_ack_err", {m_ack_o, m_err_o}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk); tick();
    @(negedge clk); chk("t6_first_grant", grant_o, 4'b0001); tick();
    cyc = '0; stb = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
